// File: rtl/md_unit_if.sv
// Operand/request and HI/LO result bundle between the EX stage and md_unit.
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport master (output start, op, a, b, input hi, lo, busy);
  modport slave  (input start, op, a, b, output hi, lo, busy);
endinterface

// File: rtl/md_unit.sv
// MIPS multiply/divide unit holding HI/LO; result lands after MULT_CYCLES/DIV_CYCLES of busy, start ignored while busy.
// Define MD_UNIT_MADD_EN to enable op 6/7 (MADD/MADDU accumulate into {hi,lo}).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst,
  md_unit_if.slave   md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic          pend_wr_q, pend_wr_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic [63:0] mul_s, mul_u;
  logic        div_sgn;
  logic [31:0] a_mag, b_mag, dvd, dvs, dvs_safe, q_raw, r_raw, q_fix, r_fix;

  // Sign-extended operands give the signed product in the low 64 bits.
  assign mul_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
  assign mul_u = {32'd0, md.a} * {32'd0, md.b};

  // One unsigned divider shared by DIV and DIVU; signed case works on magnitudes.
  assign div_sgn  = ~md.op[0];
  assign a_mag    = md.a[31] ? (32'd0 - md.a) : md.a;
  assign b_mag    = md.b[31] ? (32'd0 - md.b) : md.b;
  assign dvd      = div_sgn ? a_mag : md.a;
  assign dvs      = div_sgn ? b_mag : md.b;
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q_raw    = dvd / dvs_safe;
  assign r_raw    = dvd % dvs_safe;
  assign q_fix    = (div_sgn && (md.a[31] ^ md.b[31])) ? (32'd0 - q_raw) : q_raw;
  assign r_fix    = (div_sgn && md.a[31]) ? (32'd0 - r_raw) : r_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md.op)
            3'd0: begin
              pend_d = mul_s; pend_wr_d = 1'b1; cnt_d = MC; state_d = RUN;
            end
            3'd1: begin
              pend_d = mul_u; pend_wr_d = 1'b1; cnt_d = MC; state_d = RUN;
            end
            3'd2, 3'd3: begin
              // Divide by zero still burns the full latency but never writes.
              pend_d    = {r_fix, q_fix};
              pend_wr_d = (md.b != 32'd0);
              cnt_d     = DC;
              state_d   = RUN;
            end
            3'd4: hi_d = md.a;
            3'd5: lo_d = md.a;
`ifdef MD_UNIT_MADD_EN
            3'd6: begin
              pend_d = {hi_q, lo_q} + mul_s; pend_wr_d = 1'b1; cnt_d = MC; state_d = RUN;
            end
            3'd7: begin
              pend_d = {hi_q, lo_q} + mul_u; pend_wr_d = 1'b1; cnt_d = MC; state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  assign md.busy = (state_q == RUN);

endmodule
